// File: rtl/fe_pkg.sv
// Shared constants and types for the sequential field-element multiplier.
package fe_pkg;

  localparam int unsigned N     = 255;
  localparam int unsigned LIMB  = 17;
  localparam int unsigned NLIMB = N / LIMB;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Full unreduced product, sized to feed the reduce stage directly.
  typedef logic [2*N-1:0] prod_t;

endpackage

// File: rtl/fe_mac_row.sv
// One multiply-accumulate row: acc + (a * b_limb) << (LIMB*k).
module fe_mac_row #(
  parameter int unsigned N    = fe_pkg::N,
  parameter int unsigned LIMB = fe_pkg::LIMB,
  parameter int unsigned KW   = 4
) (
  input  logic [N-1:0]    a,
  input  logic [LIMB-1:0] b_limb,
  input  logic [KW-1:0]   k,
  input  logic [2*N-1:0]  acc,
  output logic [2*N-1:0]  acc_next
);

  logic [N+LIMB-1:0] pp;
  logic [2*N-1:0]    pp_shifted;

  // N x LIMB partial product, aligned to limb position k and added in.
  // The final sum always fits in 2N bits, so the carry-out is dropped.
  always_comb begin
    pp         = (N+LIMB)'(a) * (N+LIMB)'(b_limb);
    pp_shifted = (2*N)'(pp) << (LIMB * k);
    acc_next   = acc + pp_shifted;
  end

endmodule

// File: rtl/fe_mul_seq.sv
// Sequential N x N multiplier: one LIMB-wide slice of b per cycle,
// full 2N-bit product presented with a valid/ready handshake.
module fe_mul_seq #(
  parameter int unsigned N    = fe_pkg::N,
  parameter int unsigned LIMB = fe_pkg::LIMB
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);

  import fe_pkg::*;

  // N must be a multiple of LIMB; the limb count follows from that.
  localparam int unsigned NL = N / LIMB;
  localparam int unsigned KW = (NL > 1) ? $clog2(NL) : 1;

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;
  logic [KW-1:0]    k;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   acc_next;
  logic [LIMB-1:0]  b_limb;
  logic             accept;
  logic             last_step;

  assign b_limb = LIMB'(b_reg >> (LIMB * k));

  fe_mac_row #(
    .N    (N),
    .LIMB (LIMB),
    .KW   (KW)
  ) u_mac_row (
    .a        (a_reg),
    .b_limb   (b_limb),
    .k        (k),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (k == KW'(NL - 1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, limb counter and accumulator; p is loaded on the
  // last accumulation so it holds its previous value through IDLE/RUN
  // while still equalling the accumulator once in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      k     <= '0;
      acc   <= '0;
      p     <= '0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      k     <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      k   <= k + 1'b1;
      if (last_step) begin
        p <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_fe_mul_seq.sv
// Self-checking bench for fe_mul_seq against a plain-arithmetic model.
module tb_fe_mul_seq;

  import fe_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [254:0] a = '0;
  logic [254:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  prod_t        p;

  int checks = 0;
  int errors = 0;

  localparam prod_t PMOD = (prod_t'(1) << 255) - prod_t'(19);

  fe_mul_seq #(
    .N    (255),
    .LIMB (17)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic prod_t mul_ref(input logic [254:0] x, input logic [254:0] y);
    prod_t ex;
    prod_t ey;
    ex = prod_t'(x);
    ey = prod_t'(y);
    return ex * ey;
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] t;
    t = {$urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom};
    return t[254:0];
  endfunction

  // Present operands, wait for acceptance, then count edges to out_valid.
  task automatic run_op(input logic [254:0] av, input logic [254:0] bv,
                        output int lat, output prod_t pv);
    int w;
    w = 0;
    a = av;
    b = bv;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    pv = p;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (p !== '0) begin
      errors++;
      $display("FAIL reset_p: got %h expected 0", p);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
    end
    tick();
  endtask

  task automatic test_zero();
    int    lat;
    prod_t pv;
    run_op('0, '1, lat, pv);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 15", lat);
    end
    checks++;
    if (pv !== '0) begin
      errors++;
      $display("FAIL zero_p: got %h expected 0", pv);
    end
    finish_op();
  endtask

  task automatic test_small();
    int    lat;
    prod_t pv;
    run_op(255'd2, 255'd1, lat, pv);
    checks++;
    if (pv !== prod_t'(2)) begin
      errors++;
      $display("FAIL small_p: got %h expected 2", pv);
    end
    finish_op();
  endtask

  task automatic test_max();
    int           lat;
    prod_t        pv;
    prod_t        ones;
    prod_t        expv;
    prod_t        red_dut;
    prod_t        red_ref;
    logic [254:0] m;
    m = '1;
    ones = '1;
    expv = ones - (prod_t'(1) << 256) + prod_t'(2);
    run_op(m, m, lat, pv);
    checks++;
    if (pv !== expv) begin
      errors++;
      $display("FAIL max_p: got %h expected %h", pv, expv);
    end
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL max_latency: got %0d expected 15", lat);
    end
    red_dut = pv % PMOD;
    red_ref = ((prod_t'(m) % PMOD) * (prod_t'(m) % PMOD)) % PMOD;
    checks++;
    if (red_dut !== red_ref) begin
      errors++;
      $display("FAIL max_reduce: got %h expected %h", red_dut, red_ref);
    end
    finish_op();
  endtask

  task automatic test_stall();
    int           lat;
    prod_t        pv;
    prod_t        expv;
    logic [255:0] pat;
    pat = {8{32'hdeadbeef}};
    expv = mul_ref(pat[254:0], 255'd2);
    run_op(pat[254:0], 255'd2, lat, pv);
    checks++;
    if (pv !== expv) begin
      errors++;
      $display("FAIL stall_p: got %h expected %h", pv, expv);
    end
    // A new request during DONE must be ignored.
    a = rnd255();
    b = rnd255();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_out_valid[%0d]: got %b expected 1", i, out_valid);
      end
      checks++;
      if (p !== expv) begin
        errors++;
        $display("FAIL stall_p_hold[%0d]: got %h expected %h", i, p, expv);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release_out_valid: got %b expected 0", out_valid);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int    lat;
    int    seen;
    prod_t pv;
    a = rnd255();
    b = rnd255();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (p !== '0) begin
      errors++;
      $display("FAIL abort_p: got %h expected 0", p);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_out_valid: got %0d valid cycles expected 0", seen);
    end
    run_op(255'd3, 255'd5, lat, pv);
    checks++;
    if (pv !== prod_t'(15)) begin
      errors++;
      $display("FAIL abort_next_p: got %h expected f", pv);
    end
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL abort_next_latency: got %0d expected 15", lat);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    prod_t q[$];
    prod_t expv;
    int    cyc;
    int    last_acc;
    int    done;
    logic  acc_now;
    cyc = 0;
    last_acc = -1;
    done = 0;
    out_ready = 1'b1;
    a = rnd255();
    b = rnd255();
    in_valid = 1'b1;
    while (done < 6 && cyc < 300) begin
      if (out_valid) begin
        if (q.size() > 0) begin
          expv = q.pop_front();
          checks++;
          if (p !== expv) begin
            errors++;
            $display("FAIL b2b_p[%0d]: got %h expected %h", done, p, expv);
          end
        end
        done++;
      end
      acc_now = in_ready;
      if (acc_now) begin
        q.push_back(mul_ref(a, b));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 17) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected 17", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      tick();
      cyc++;
      if (acc_now) begin
        a = rnd255();
        b = rnd255();
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 6) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d results expected 6", done);
    end
    repeat (20) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_zero();
    test_small();
    test_max();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fe_mul_seq.md
FE_MUL_SEQ -- requirements
Module: fe_mul_seq

Interface
REQ-001 The block SHALL have parameter N, default 255, giving the operand width in bits.
REQ-002 The block SHALL have parameter LIMB, default 17, giving the multiplier-operand slice width in bits; N SHALL be a multiple of LIMB.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a and b are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, inputs, N bits each: unsigned operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: product p is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer (the reduce stage) takes p.
REQ-010 The block SHALL have port p, output, 2N bits: the full unreduced product a*b, sized to feed reduce directly.

Function
REQ-011 The block SHALL use states IDLE, RUN and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE with rst low; out_valid SHALL be 1 only in DONE.
REQ-013 IDLE: on the edge where in_valid && in_ready, the block SHALL latch a and b, clear the 2N-bit accumulator, set limb counter k=0 and go to RUN; a and b SHALL be ignored at all other times.
REQ-014 RUN: each cycle the block SHALL compute acc += (a_reg * b_reg[LIMB*k +: LIMB]) << (LIMB*k) and then k++.
REQ-015 The accumulator SHALL be 2N bits; the final sum SHALL never exceed 2N bits, so no carry-out is kept.
REQ-016 When k = N/LIMB-1 (14 at defaults), the edge that performs the last accumulation SHALL also move the block to DONE.
REQ-017 out_valid SHALL rise exactly N/LIMB (15) edges after the accepting edge.
REQ-018 DONE: p and out_valid SHALL hold stable until out_valid && out_ready.
REQ-019 On the handshake edge of REQ-018 the block SHALL return to IDLE; a new operand pair SHALL be accepted no earlier than the following edge, and at most one operation SHALL be in flight.
REQ-020 p SHALL equal the accumulator register (registered output); p SHALL keep its last value in IDLE and RUN but is meaningful only while out_valid=1.
REQ-021 in_valid asserted outside IDLE SHALL have no effect; the upstream source SHALL hold its operands until in_ready.
REQ-022 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL set state=IDLE, k=0, accumulator and p=0, and out_valid=0; in_ready SHALL be 0 while rst is high.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation with no output handshake; the first edge with rst low SHALL find the block in IDLE with in_ready=1.

Structure
REQ-025 Shared package fe_pkg SHALL hold the constants N, LIMB and NLIMB=N/LIMB, the state enum (IDLE, RUN, DONE), and the type for the 2N-bit product.
REQ-026 One sub-module fe_mac_row SHALL compute the N x LIMB partial product plus shifted accumulate; counter and handshake logic SHALL stay in fe_mul_seq.
REQ-027 No other sub-modules SHALL be used.

Verification
REQ-028 Bench SHALL cover: a=0, b=2^255-1 -> out_valid 15 cycles after accept, p=0.
REQ-029 Bench SHALL cover: a=2, b=1 -> p=2.
REQ-030 Bench SHALL cover: a=b=2^255-1 -> p=2^510-2^256+1; reduce(p) SHALL match the reference model mod 2^255-19.
REQ-031 Bench SHALL cover: a={8{32'hdeadbeef}}, b=2, out_ready held low 20 cycles -> p and out_valid stay stable and in_ready stays 0 throughout; after out_ready=1 for one cycle -> IDLE and in_ready=1 on the next cycle.
REQ-032 Bench SHALL cover: rst pulsed for one cycle at RUN k=7 -> no out_valid; the next operation a=3, b=5 gives p=15 with normal latency.
REQ-033 Bench SHALL cover: back-to-back random pairs with out_ready tied to 1 -> each p matches a*b from the model, and the accept-to-accept spacing is exactly 17 cycles.
